// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C read-only target.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_TX,
    ST_MACK,
    ST_IGNORE
  } state_e;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'b1001101;
  localparam logic       I2C_READ           = 1'b1;
  localparam int         BIT_CNT_W          = 4;

  localparam logic [BIT_CNT_W-1:0] BYTE_BITS = BIT_CNT_W'(8);

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one bus pin with a delayed copy for edge pulses.
module i2c_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // [0] metastability stage, [1] synchronized level, [2] previous level
  logic [2:0] sr_q, sr_d;

  always_comb begin
    sr_d = {sr_q[1:0], din};
  end

  // NOTE: flops take non-blocking assignments so every register samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr_q <= 3'b111;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign level = sr_q[1];
  assign rise  = sr_q[1] & ~sr_q[2];
  assign fall  = ~sr_q[1] & sr_q[2];

endmodule

// File: rtl/i2c_target.sv
// I2C target answering a 16-bit read: address match, ACK, then the latched
// word MSB-first on open-drain SDA, wrapping while the master keeps ACKing.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] data_in,
  output logic        data_ack,
  output logic        busy,
  output logic        tx_done
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (
    .clk   (clk),
    .resetn(resetn),
    .din   (scl),
    .level (scl_s),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk   (clk),
    .resetn(resetn),
    .din   (sda),
    .level (sda_s),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  state_e               state_q,    state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [7:0]           addr_sr_q,  addr_sr_d;
  logic [15:0]          tx_sr_q,    tx_sr_d;
  logic                 byte_idx_q, byte_idx_d;
  logic                 rose_q,     rose_d;
  logic                 sda_oe_q,   sda_oe_d;
  logic                 busy_q,     busy_d;
  logic                 data_ack_q, data_ack_d;
  logic                 tx_done_q,  tx_done_d;

  logic addr_hit;
  logic tx_bit;

  assign addr_hit = (addr_sr_q[7:1] == SLAVE_ADDR) && (addr_sr_q[0] == I2C_READ);
  // The word is never shifted, so a wrap back to byte 0 re-reads it intact.
  assign tx_bit   = tx_sr_q[{~byte_idx_q, ~bit_cnt_q[2:0]}];

  // NOTE: every signal gets its hold value before the case so no path leaves
  // one unassigned; a missing default here infers a latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    addr_sr_d  = addr_sr_q;
    tx_sr_d    = tx_sr_q;
    byte_idx_d = byte_idx_q;
    rose_d     = rose_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    data_ack_d = 1'b0;
    tx_done_d  = 1'b0;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      rose_d    = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_IGNORE: begin
          sda_oe_d = 1'b0;
        end
        ST_ADDR: begin
          if (scl_rise && (bit_cnt_q < BYTE_BITS)) begin
            addr_sr_d = {addr_sr_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (scl_fall && (bit_cnt_q == BYTE_BITS)) begin
            if (addr_hit) begin
              sda_oe_d   = 1'b1;
              tx_sr_d    = data_in;
              data_ack_d = 1'b1;
              busy_d     = 1'b1;
              state_d    = ST_ADDR_ACK;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d   = ~tx_sr_q[15];
            bit_cnt_d  = '0;
            byte_idx_d = 1'b0;
            rose_d     = 1'b0;
            state_d    = ST_TX;
          end
        end
        ST_TX: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            rose_d    = 1'b1;
          end else if (scl_fall && rose_q) begin
            rose_d = 1'b0;
            if (bit_cnt_q == BYTE_BITS) begin
              sda_oe_d = 1'b0;
              state_d  = ST_MACK;
            end else begin
              sda_oe_d = ~tx_bit;
            end
          end
        end
        ST_MACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              // Pretend a rise already happened so the coming fall drives the MSB.
              byte_idx_d = ~byte_idx_q;
              bit_cnt_d  = '0;
              rose_d     = 1'b1;
              state_d    = ST_TX;
            end else begin
              tx_done_d = 1'b1;
              busy_d    = 1'b0;
              state_d   = ST_IGNORE;
            end
          end
        end
        default: begin
          sda_oe_d = 1'b0;
          state_d  = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      addr_sr_q  <= '0;
      tx_sr_q    <= '0;
      byte_idx_q <= 1'b0;
      rose_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      data_ack_q <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      addr_sr_q  <= addr_sr_d;
      tx_sr_q    <= tx_sr_d;
      byte_idx_q <= byte_idx_d;
      rose_q     <= rose_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      data_ack_q <= data_ack_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign data_ack = data_ack_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged I2C master issues reads, a scoreboard
// matches DUT pulses and bus bytes against a transaction-level model.
module tb_i2c_target;

  localparam int H = 8;  // clk cycles per SCL half period

  typedef enum logic [1:0] {EV_DATA_ACK, EV_ADDR_ACK, EV_BYTE, EV_TX_DONE} ev_kind_e;
  typedef struct packed {
    ev_kind_e   kind;
    logic [7:0] val;
  } ev_t;

  logic        clk     = 1'b0;
  logic        resetn  = 1'b0;
  logic        scl_drv = 1'b1;
  logic        sda_low = 1'b0;
  logic [15:0] data_in = 16'h0000;
  wire         sda;
  logic        data_ack, busy, tx_done;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_target dut (
    .clk     (clk),
    .resetn  (resetn),
    .scl     (scl_drv),
    .sda     (sda),
    .data_in (data_in),
    .data_ack(data_ack),
    .busy    (busy),
    .tx_done (tx_done)
  );

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  checks   = 0;
  int  failures = 0;
  bit  done     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ev_t mk(input ev_kind_e k, input logic [7:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    return e;
  endfunction

  // Reference model: which addresses are answered and which byte comes next.
  function automatic bit model_accepts(input logic [7:0] a);
    return (a[7:1] == 7'h4D) && (a[0] == 1'b1);
  endfunction

  function automatic logic [7:0] model_byte(input logic [15:0] w, input int i);
    return (i % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  task automatic score(input ev_t got);
    ev_t want;
    check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      check("sb_kind", 32'(got.kind), 32'(want.kind));
      check("sb_val", 32'(got.val), 32'(want.val));
    end
  endtask

  initial begin : monitor
    while (!done) begin
      @(negedge clk);
      if (data_ack) score(mk(EV_DATA_ACK, 8'h00));
      if (tx_done)  score(mk(EV_TX_DONE, 8'h00));
      while (obs_q.size() != 0) score(obs_q.pop_front());
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic half();
    repeat (H) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    repeat (2) @(negedge clk);
    sda_low = !b;
    repeat (H - 2) @(negedge clk);
    scl_drv = 1'b1;
    half();
    scl_drv = 1'b0;
  endtask

  task automatic recv_bit(output bit b);
    repeat (2) @(negedge clk);
    sda_low = 1'b0;
    repeat (H - 2) @(negedge clk);
    scl_drv = 1'b1;
    repeat (H / 2) @(negedge clk);
    b = sda;
    repeat (H - H / 2) @(negedge clk);
    scl_drv = 1'b0;
  endtask

  task automatic bus_start();
    repeat (2) @(negedge clk);
    sda_low = 1'b0;
    half();
    scl_drv = 1'b1;
    half();
    sda_low = 1'b1;
    half();
    scl_drv = 1'b0;
  endtask

  task automatic bus_stop();
    repeat (2) @(negedge clk);
    sda_low = 1'b1;
    half();
    scl_drv = 1'b1;
    half();
    sda_low = 1'b0;
    half();
  endtask

  task automatic write_byte(input logic [7:0] b, output bit ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack);
    obs_q.push_back(mk(EV_ADDR_ACK, {7'b0, ack}));
  endtask

  task automatic read_byte(input bit master_ack, output logic [7:0] b);
    bit x;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(x);
      b[i] = x;
    end
    obs_q.push_back(mk(EV_BYTE, b));
    send_bit(!master_ack);
  endtask

  task automatic addr_phase(input logic [7:0] a, input logic [15:0] word, output bit acc);
    bit ack;
    acc     = model_accepts(a);
    data_in = word;
    if (acc) begin
      exp_q.push_back(mk(EV_DATA_ACK, 8'h00));
      exp_q.push_back(mk(EV_ADDR_ACK, 8'h00));
    end else begin
      exp_q.push_back(mk(EV_ADDR_ACK, 8'h01));
    end
    write_byte(a, ack);
    @(negedge clk);
    check("busy_after_addr", 32'(busy), 32'(acc));
  endtask

  task automatic data_phase(input logic [15:0] word, input int nbytes, input bit change_mid);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) exp_q.push_back(mk(EV_BYTE, model_byte(word, i)));
    exp_q.push_back(mk(EV_TX_DONE, 8'h00));
    for (int i = 0; i < nbytes; i++) begin
      if (change_mid && i == 1) data_in = ~word;
      read_byte(i != nbytes - 1, b);
    end
    @(negedge clk);
    check("busy_after_nack", 32'(busy), 32'd0);
  endtask

  task automatic ignore_phase();
    logic [7:0] b;
    bit x;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(x);
      b[i] = x;
    end
    check("ignored_sda", 32'(b), 32'hFF);
    check("ignored_busy", 32'(busy), 32'd0);
  endtask

  task automatic read_txn(input logic [7:0] a, input logic [15:0] word, input int nbytes,
                          input bit change_mid);
    bit acc;
    bus_start();
    addr_phase(a, word, acc);
    if (acc) data_phase(word, nbytes, change_mid);
    else ignore_phase();
    bus_stop();
  endtask

  // Reads 3 bits of 0x1234 (bit 12 then sits released) and breaks off with a
  // STOP or a repeated START; bit 11 is 0, so a target that kept driving
  // would corrupt the following address.
  task automatic abort_txn(input bit restart);
    bit         acc, x;
    logic [2:0] bits;
    logic [7:0] unused_b;
    bus_start();
    addr_phase(8'h9B, 16'h1234, acc);
    for (int i = 2; i >= 0; i--) begin
      recv_bit(x);
      bits[i] = x;
    end
    check("abort_first_bits", 32'(bits), 32'h0);
    repeat (2) @(negedge clk);
    if (restart) begin
      sda_low = 1'b0;
      half();
      scl_drv = 1'b1;
      half();
      sda_low = 1'b1;
      repeat (5) @(negedge clk);
      check("busy_after_rstart", 32'(busy), 32'd0);
      repeat (H - 5) @(negedge clk);
      scl_drv = 1'b0;
      repeat (2) @(negedge clk);
      sda_low = 1'b0;
      repeat (5) @(negedge clk);
      check("sda_free_after_rstart", 32'(sda), 32'd1);
      addr_phase(8'h9B, 16'hBEEF, acc);
      data_phase(16'hBEEF, 2, 1'b0);
      bus_stop();
    end else begin
      sda_low = 1'b1;
      half();
      scl_drv = 1'b1;
      half();
      sda_low = 1'b0;
      repeat (5) @(negedge clk);
      check("busy_after_stop", 32'(busy), 32'd0);
      check("sda_free_after_stop", 32'(sda), 32'd1);
      half();
    end
    unused_b = 8'h00;
  endtask

  initial begin : stimulus
    bit         acc;
    logic [7:0] a;
    logic [15:0] w;
    int         nb;

    repeat (4) @(negedge clk);
    check("rst_sda", 32'(sda), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data_ack", 32'(data_ack), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    resetn = 1'b1;
    half();

    read_txn(8'h9B, 16'hA5C3, 2, 1'b0);
    read_txn(8'h9D, 16'h5A5A, 1, 1'b0);
    read_txn(8'h9A, 16'hFFFF, 1, 1'b0);
    read_txn(8'h9B, 16'h1234, 3, 1'b1);
    abort_txn(1'b0);
    abort_txn(1'b1);

    // Reset while the target drives the 0 MSB of 0x1234.
    bus_start();
    addr_phase(8'h9B, 16'h1234, acc);
    repeat (4) @(negedge clk);
    check("sda_driving_msb", 32'(sda), 32'd0);
    resetn = 1'b0;
    #1;
    check("mid_rst_sda", 32'(sda), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data_ack", 32'(data_ack), 32'd0);
    check("mid_rst_tx_done", 32'(tx_done), 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    half();
    read_txn(8'h9B, 16'h0F1E, 2, 1'b0);

    for (int n = 0; n < 12; n++) begin
      a  = ($urandom_range(0, 3) != 0) ? 8'h9B : 8'($urandom);
      w  = 16'($urandom);
      nb = int'($urandom_range(1, 4));
      read_txn(a, w, nb, 1'($urandom_range(0, 1)));
    end

    repeat (20) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

Clocked I2C target (slave) that answers the 16-bit read issued by `i2c_master`. It is the bus-side model and sensor-emulation block for the same two-wire bus.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches the 7-bit address on a read request and shifts out a latched 16-bit word MSB-first with open-drain SDA.
- Used in loopback benches against `i2c_master` and as a register-readout target in FPGA builds.

## Interface
- `SLAVE_ADDR`, 7'b1001101, address this target responds to.
- `clk`  input  1  system clock; all logic on rising edge.
- `resetn`  input  1  asynchronous, active-low reset.
- `scl`  input  1  bus clock from master (pulled up externally; treat z as 1).
- `sda`  inout  1  open-drain: driven 0 when `sda_oe`=1, else 1'bz.
- `data_in`  input  16  word to return; sampled on address match.
- `data_ack`  output  1  one-cycle pulse when `data_in` is latched.
- `busy`  output  1  high from address match until NACK, STOP, or repeated START.
- `tx_done`  output  1  one-cycle pulse when the master NACKs a data byte.

## Operation
- Input conditioning: 2-FF synchronizer on `scl` and on `sda`, plus one delayed copy of each for edge detection. All decisions use the synchronized values.
- START: sync SDA falls while sync SCL is high. Enter ADDR from any state, reset the bit counter, release SDA.
- STOP: sync SDA rises while sync SCL is high. Enter IDLE from any state, release SDA, clear `busy`.
- IDLE: SDA released; wait for START.
- ADDR: shift SDA into `addr_sr` on each SCL rise, MSB first. After the 8th rise, compare `addr_sr[7:1]` with `SLAVE_ADDR` and check `addr_sr[0]`.
  - Match and R/W=1: at the next SCL fall, set `sda_oe`=1 (ACK), latch `data_in` into `tx_sr`, pulse `data_ack`, set `busy`. Go to ADDR_ACK.
  - Mismatch or R/W=0: enter IGNORE with SDA released. No ACK; writes are not supported.
- ADDR_ACK: at the next SCL fall, present bit 15 (`sda_oe` = ~bit), reset the bit counter, set byte index 0. Go to TX.
- TX: each SCL rise increments the bit counter. Each SCL fall after a rise presents the next bit.
  - After the 8th rise, the following fall releases SDA. Go to MACK.
- MACK: sample SDA on the SCL rise.
  - 0 (ACK): toggle byte index. The next fall presents the MSB of the next byte; after byte 1 it wraps to byte 0 of the same latched word, with no re-latch. Go to TX.
  - 1 (NACK): pulse `tx_done`, clear `busy`. Go to IGNORE.
- IGNORE: SDA released; leave only on START (to ADDR) or STOP (to IDLE).
- START and STOP take priority over any SCL edge detected in the same cycle.

## Timing
- Reset values: `sda_oe`=0 (SDA=z), `busy`=0, `data_ack`=0, `tx_done`=0, state IDLE, counters 0. Synchronizers reset to 1.
- Reset asserted mid-byte releases SDA immediately (asynchronous).
- Edge-detect latency is 3 `clk` from a pin edge. SDA changes 1 `clk` after a detected SCL fall, giving nonzero hold time.
- Requires SCL high and low phases of at least 6 `clk` each. The default `CLK_DIV`=250 gives far more margin than this.
- `data_ack` is asserted in the same cycle `sda_oe` goes 1 for the address ACK.
- `tx_done` is asserted 1 cycle after the SCL rise on which the NACK is sampled.
- Repeated START during TX releases SDA in the cycle it is detected.

## Structure
- Package `i2c_pkg` holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, TX, MACK, IGNORE);
  - the default `SLAVE_ADDR`;
  - the `I2C_READ`=1 constant;
  - the bit-count width (4).
- Sub-module `i2c_sync_edge`: 2-FF synchronizer with rise/fall pulse outputs, instantiated once for `scl` and once for `sda`. START/STOP decoding stays in the top level.

## Test plan
- Read 0x4D: master sends 0x9B, `data_in`=16'hA5C3. Expected: ACK at the 9th clock, `data_ack` pulse, bytes 0xA5 then 0xC3 on SDA. Master ACK then NACK gives a `tx_done` pulse and `busy` low.
- Address mismatch: master sends 0x9D (addr 0x4E). Expected: SDA stays z through the 9th clock, no `data_ack`, state IGNORE until STOP.
- Write request: master sends 0x9A. Expected: no ACK, `busy` stays 0.
- Master ACKs 3 bytes with `data_in`=16'h1234. Expected: bytes 0x12, 0x34, 0x12, and a change to `data_in` mid-transfer has no effect.
- STOP or repeated START after 3 bits of byte 0. Expected: SDA released the cycle it is detected. A repeated START followed by 0x9B re-latches `data_in`.
- `resetn` low while driving a 0 bit. Expected: SDA z immediately and all outputs 0. After release, the target responds to a fresh START normally.
